// File: rtl/speed_pkg.sv
// Shared speed-path constants: default tachometer parameters and FSM state encoding.
package speed_pkg;

  localparam int GATE_CYCLES_DEF = 25_000_000;
  localparam int CNT_W_DEF       = 16;
  localparam int FILTER_DEF      = 4;
  localparam int STALL_GATES_DEF = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_filter.sv
// Encoder input conditioning: 2-FF sync, FILTER-cycle glitch filter, registered rising-edge pulse.
// Pin-to-edge_out latency is 2 + FILTER + 1 cycles; no flow control.
module pulse_filter
  import speed_pkg::*;
#(
  parameter int FILTER = FILTER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic edge_out
);

  localparam int FW = cnt_width(FILTER - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER - 1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic          filt_q;
  logic [FW-1:0] stable_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      filt       <= 1'b0;
      filt_q     <= 1'b0;
      stable_cnt <= '0;
      edge_out   <= 1'b0;
    end else begin
      sync1    <= d_in;
      sync2    <= sync1;
      filt_q   <= filt;
      edge_out <= filt & ~filt_q;
      // Any return to the accepted level restarts the qualification run.
      if (sync2 == filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == F_LAST) begin
        filt       <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/speed_meter.sv
// Encoder tachometer: counts filtered rising edges per GATE_CYCLES window, latches speed/overflow/stall.
// One speed_valid strobe per completed window; dropping enable discards the partial window.
module speed_meter
  import speed_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FILTER      = FILTER_DEF,
  parameter int STALL_GATES = STALL_GATES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enable,
  output logic [CNT_W-1:0] speed,
  output logic             speed_valid,
  output logic             overflow,
  output logic             stall
);

  localparam int GW = cnt_width(GATE_CYCLES - 1);
  localparam int SW = cnt_width(STALL_GATES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_GATES);

  logic [0:0]       state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic             sat;
  logic [SW-1:0]    zero_cnt;
  logic             edge_det;

  logic [CNT_W-1:0] cnt_now;
  logic             sat_now;
  logic [SW-1:0]    zero_next;

  pulse_filter #(.FILTER(FILTER)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .d_in     (enc_a),
    .edge_out (edge_det)
  );

  // Count as it stands including this cycle's edge, so the terminal cycle's edge is kept.
  always_comb begin
    cnt_now = pulse_cnt;
    sat_now = sat;
    if (edge_det) begin
      if (pulse_cnt == {CNT_W{1'b1}}) sat_now = 1'b1;
      else                            cnt_now = pulse_cnt + 1'b1;
    end
    zero_next = '0;
    if (cnt_now == '0) zero_next = (zero_cnt == STALL_MAX) ? zero_cnt : zero_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gate_cnt    <= '0;
      pulse_cnt   <= '0;
      sat         <= 1'b0;
      zero_cnt    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      overflow    <= 1'b0;
      stall       <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (state == ST_IDLE || !enable) begin
        state     <= enable ? ST_RUN : ST_IDLE;
        gate_cnt  <= '0;
        pulse_cnt <= '0;
        sat       <= 1'b0;
      end else if (gate_cnt == GATE_LAST) begin
        speed       <= cnt_now;
        overflow    <= sat_now;
        speed_valid <= 1'b1;
        zero_cnt    <= zero_next;
        stall       <= (zero_next == STALL_MAX);
        gate_cnt    <= '0;
        pulse_cnt   <= '0;
        sat         <= 1'b0;
      end else begin
        gate_cnt  <= gate_cnt + 1'b1;
        pulse_cnt <= cnt_now;
        sat       <= sat_now;
      end
    end
  end

endmodule
